// File: rtl/roi_pkg.sv
// Shared definitions for the ROI padding stream block: FSM states, the bit
// positions of the packed corner coordinates, and a clamp helper.
package roi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } roi_state_e;

    localparam int X_MSB = 26;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 9;
    localparam int Y_LSB = 0;

    function automatic logic [31:0] clamp_coord(input logic [31:0] v,
                                                input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/roi_xy_cnt.sv
// Raster position counter: x wraps at WIDTH-1 and carries into y, which wraps
// at HEIGHT-1. Clear has priority over enable.
module roi_xy_cnt #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int XW     = 10,
    parameter int YW     = 10
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          x_last,
    output logic          y_last
);

    assign x_last = (x == XW'(WIDTH - 1));
    assign y_last = (y == YW'(HEIGHT - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/roi_pad_axis.sv
// Expands an ROI pixel stream into a full WIDTH x HEIGHT frame, filling every
// position outside the ROI (or after an early source tlast) with BG.
module roi_pad_axis
    import roi_pkg::*;
#(
    parameter int                WIDTH  = 800,
    parameter int                HEIGHT = 600,
    parameter int                BIT_D  = 8,
    parameter int                BIT_C  = 32,
    parameter logic [BIT_D-1:0]  BG     = '0
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             start_i,
    input  logic [BIT_C-1:0] xy_0_i,
    input  logic [BIT_C-1:0] xy_1_i,
    input  logic [BIT_D-1:0] s_tdata_i,
    input  logic             s_tvalid_i,
    input  logic             s_tlast_i,
    output logic             s_tready_o,
    output logic [BIT_D-1:0] m_tdata_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic             m_tuser_o,
    output logic             frame_done_o,
    output logic             err_o,
    output roi_state_e       state_o
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [31:0] XLIM = 32'(WIDTH - 1);
    localparam logic [31:0] YLIM = 32'(HEIGHT - 1);

    // Handshakes: a beat moves on either stream only in a cycle where both
    // valid and ready are high at the rising edge; a master beat, once valid,
    // keeps data and flags unchanged until it is taken.

    roi_state_e    state;
    logic [XW-1:0] xmin, xmax;
    logic [YW-1:0] ymin, ymax;
    logic          roi_done;
    logic          need_flush;
    logic          issued_all;

    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic          ox_last, oy_last;

    logic [XW-1:0] x0c, x1c;
    logic [YW-1:0] y0c, y1c;
    logic          unused_bits;

    logic          ld;
    logic          in_roi;
    logic          take_src;
    logic          roi_last;
    logic          beat_load;
    logic          cnt_clr;

    assign x0c = XW'(clamp_coord(32'(xy_0_i[X_MSB:X_LSB]), XLIM));
    assign x1c = XW'(clamp_coord(32'(xy_1_i[X_MSB:X_LSB]), XLIM));
    assign y0c = YW'(clamp_coord(32'(xy_0_i[Y_MSB:Y_LSB]), YLIM));
    assign y1c = YW'(clamp_coord(32'(xy_1_i[Y_MSB:Y_LSB]), YLIM));
    assign unused_bits = ^{xy_0_i, xy_1_i};

    assign ld       = !m_tvalid_o || m_tready_i;
    assign in_roi   = (ox >= xmin) && (ox <= xmax) && (oy >= ymin) && (oy <= ymax);
    assign take_src = in_roi && !roi_done;
    assign roi_last = (ox == xmax) && (oy == ymax);

    // Once the final beat is in the output register no further positions are
    // generated; the FSM only waits for that beat to be taken.
    assign beat_load = (state == ST_RUN) && !issued_all && ld
                       && (!take_src || s_tvalid_i);
    assign cnt_clr   = (state == ST_IDLE) && start_i;

    assign s_tready_o = ((state == ST_RUN) && !issued_all && take_src && ld)
                        || (state == ST_FLUSH);
    assign state_o    = state;

    roi_xy_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_xy_cnt (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .clr    (cnt_clr),
        .en     (beat_load),
        .x      (ox),
        .y      (oy),
        .x_last (ox_last),
        .y_last (oy_last)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state        <= ST_IDLE;
            xmin         <= '0;
            xmax         <= '0;
            ymin         <= '0;
            ymax         <= '0;
            roi_done     <= 1'b0;
            need_flush   <= 1'b0;
            issued_all   <= 1'b0;
            m_tdata_o    <= '0;
            m_tvalid_o   <= 1'b0;
            m_tlast_o    <= 1'b0;
            m_tuser_o    <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        xmin       <= (x0c < x1c) ? x0c : x1c;
                        xmax       <= (x0c < x1c) ? x1c : x0c;
                        ymin       <= (y0c < y1c) ? y0c : y1c;
                        ymax       <= (y0c < y1c) ? y1c : y0c;
                        roi_done   <= 1'b0;
                        need_flush <= 1'b0;
                        issued_all <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issued_all) begin
                        if (m_tready_i) begin
                            m_tvalid_o   <= 1'b0;
                            m_tlast_o    <= 1'b0;
                            m_tuser_o    <= 1'b0;
                            frame_done_o <= 1'b1;
                            state        <= need_flush ? ST_FLUSH : ST_IDLE;
                        end
                    end else if (ld) begin
                        if (take_src && !s_tvalid_i) begin
                            m_tvalid_o <= 1'b0;
                        end else begin
                            m_tdata_o  <= take_src ? s_tdata_i : BG;
                            m_tvalid_o <= 1'b1;
                            m_tuser_o  <= (ox == '0) && (oy == '0);
                            m_tlast_o  <= ox_last && oy_last;
                            if (ox_last && oy_last) begin
                                issued_all <= 1'b1;
                            end
                        end
                        if (take_src && s_tvalid_i) begin
                            if (s_tlast_i && !roi_last) begin
                                roi_done <= 1'b1;
                                err_o    <= 1'b1;
                            end
                            if (!s_tlast_i && roi_last) begin
                                need_flush <= 1'b1;
                                err_o      <= 1'b1;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (s_tvalid_i && s_tlast_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
